// File: rtl/cfg_write_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : cfg_write_arbiter_pkg                                            |
// | Brief   : Shared state encoding, default widths and helpers for the        |
// |           config write arbiter.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cfg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_def_aw  = 4;
  localparam int c_def_dw  = 7;
  localparam int c_def_tmo = 255;

  // Counter must be able to hold the largest allowed TMO (255).
  localparam int c_tmo_cnt_w = 8;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// +----------------------------------------------------------------------------+
// | Module  : rr_select                                                        |
// | Brief   : Combinational round-robin pick, searching from last_grant+1.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_select
  import cfg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int GW   = grant_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic            any,
  output logic [GW-1:0]   grant
);

  int          w_idx_i;
  logic [GW-1:0] w_idx;

  always_comb begin
    any     = 1'b0;
    grant   = '0;
    w_idx_i = 0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx_i = int'(last_grant) + k;
      if (w_idx_i >= NREQ) w_idx_i = w_idx_i - NREQ;
      w_idx = w_idx_i[GW-1:0];
      if (!any && req[w_idx]) begin
        any   = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfg_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : cfg_write_arbiter                                                |
// | Brief   : Round-robin arbiter issuing one AW/W/B write per grant.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cfg_write_arbiter
  import cfg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = c_def_aw,
  parameter int DW   = c_def_dw,
  parameter int TMO  = c_def_tmo
) (
  input  logic              ACLK,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              AWVALID,
  output logic [AW-1:0]     AWADDR,
  output logic              WVALID,
  output logic [DW-1:0]     WDATA,
  output logic              BREADY,
  input  logic              AWREADY,
  input  logic              WREADY,
  input  logic              BVALID
);

  localparam int c_gw = grant_width(NREQ);
  localparam logic [c_tmo_cnt_w-1:0] c_tmo     = c_tmo_cnt_w'(TMO);
  localparam logic [c_tmo_cnt_w-1:0] c_cnt_one = c_tmo_cnt_w'(1);
  localparam logic [c_gw-1:0]        c_last_rst = c_gw'(NREQ - 1);

  state_t                 r_state, w_state_nxt;
  logic [c_gw-1:0]        r_grant, w_grant_nxt;
  logic [c_gw-1:0]        r_last_grant, w_last_nxt;
  logic [c_tmo_cnt_w-1:0] r_tmo_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   r_timeout, w_timeout_nxt;
  logic                   w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
  logic [AW-1:0]          w_awaddr_nxt;
  logic [DW-1:0]          w_wdata_nxt;
  logic [NREQ-1:0]        w_done_nxt;
  logic                   w_err_nxt, w_busy_nxt;
  logic                   w_any;
  logic [c_gw-1:0]        w_sel;

  rr_select #(
    .NREQ (NREQ),
    .GW   (c_gw)
  ) u_rr_select (
    .req        (req),
    .last_grant (r_last_grant),
    .any        (w_any),
    .grant      (w_sel)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last_grant;
    w_cnt_nxt     = r_tmo_cnt;
    w_timeout_nxt = r_timeout;
    w_awvalid_nxt = AWVALID;
    w_awaddr_nxt  = AWADDR;
    w_wvalid_nxt  = WVALID;
    w_wdata_nxt   = WDATA;
    w_bready_nxt  = BREADY;
    w_done_nxt    = '0;
    w_err_nxt     = 1'b0;
    w_cnt_inc     = r_tmo_cnt + c_cnt_one;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt   = w_sel;
          w_awaddr_nxt  = req_addr[w_sel*AW +: AW];
          w_wdata_nxt   = req_data[w_sel*DW +: DW];
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (AWVALID && AWREADY) w_awvalid_nxt = 1'b0;
        if (WVALID && WREADY)   w_wvalid_nxt  = 1'b0;
        // Both VALIDs low next cycle means both channels have handshaken.
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt  = 1'b1;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = RESP;
        end
      end
      RESP: begin
        if (BVALID && BREADY) begin
          w_bready_nxt = 1'b0;
          w_state_nxt  = DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_tmo) begin
            w_bready_nxt  = 1'b0;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = DONE;
          end
        end
      end
      DONE: begin
        w_done_nxt[r_grant] = 1'b1;
        w_err_nxt           = r_timeout;
        w_last_nxt          = r_grant;
        w_state_nxt         = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= c_last_rst;
      r_tmo_cnt    <= '0;
      r_timeout    <= 1'b0;
      AWVALID      <= 1'b0;
      AWADDR       <= '0;
      WVALID       <= 1'b0;
      WDATA        <= '0;
      BREADY       <= 1'b0;
      done         <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_tmo_cnt    <= w_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
      AWVALID      <= w_awvalid_nxt;
      AWADDR       <= w_awaddr_nxt;
      WVALID       <= w_wvalid_nxt;
      WDATA        <= w_wdata_nxt;
      BREADY       <= w_bready_nxt;
      done         <= w_done_nxt;
      err          <= w_err_nxt;
      busy         <= w_busy_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfg_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_cfg_write_arbiter                                             |
// | Brief   : Vector table plus directed corner sequences for the arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_cfg_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 7;
  localparam int TMO  = 8;

  logic              ACLK = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   done;
  logic              err, busy;
  logic              AWVALID, WVALID, BREADY;
  logic [AW-1:0]     AWADDR;
  logic [DW-1:0]     WDATA;
  logic              AWREADY, WREADY, BVALID;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  req;
    logic [11:0] addr;
    logic [20:0] data;
    int          grant;
    logic [3:0]  eaddr;
    logic [6:0]  edata;
  } vec_t;

  vec_t vecs[9];

  cfg_write_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW),
    .TMO  (TMO)
  ) dut (
    .ACLK     (ACLK),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .AWVALID  (AWVALID),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WDATA    (WDATA),
    .BREADY   (BREADY),
    .AWREADY  (AWREADY),
    .WREADY   (WREADY),
    .BVALID   (BVALID)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    bit seen = 1'b0;
    bit got  = 1'b0;
    req      = v.req;
    req_addr = v.addr;
    req_data = v.data;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge ACLK);
      if (AWVALID && !seen) begin
        seen = 1'b1;
        check($sformatf("vec%0d AWADDR", n), 32'(AWADDR), 32'(v.eaddr));
        check($sformatf("vec%0d WDATA", n), 32'(WDATA), 32'(v.edata));
      end
      if (done != 3'b000) begin
        got = 1'b1;
        check($sformatf("vec%0d done", n), 32'(done), 32'(3'b001 << v.grant));
        check($sformatf("vec%0d err", n), 32'(err), 32'(0));
        check($sformatf("vec%0d issued", n), 32'(seen), 32'(1));
        req = req & ~done;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL vec%0d no done within 16 cycles: got none, expected 0x%0h", n, 3'b001 << v.grant);
    end
  endtask

  initial begin
    int  n;
    bit  fell;
    bit  hit;

    // {req, addr{a2,a1,a0}, data{d2,d1,d0}, grant, AWADDR, WDATA}; starts with last_grant=0
    vecs[0] = '{3'b111, 12'hCBA, {7'h33, 7'h22, 7'h11}, 1, 4'hB, 7'h22};
    vecs[1] = '{3'b111, 12'hCBA, {7'h33, 7'h22, 7'h11}, 2, 4'hC, 7'h33};
    vecs[2] = '{3'b111, 12'hCBA, {7'h33, 7'h22, 7'h11}, 0, 4'hA, 7'h11};
    vecs[3] = '{3'b111, 12'h5E9, {7'h7F, 7'h40, 7'h01}, 1, 4'hE, 7'h40};
    vecs[4] = '{3'b101, 12'h5E9, {7'h7F, 7'h40, 7'h01}, 2, 4'h5, 7'h7F};
    vecs[5] = '{3'b011, 12'hCBA, {7'h33, 7'h22, 7'h11}, 0, 4'hA, 7'h11};
    vecs[6] = '{3'b100, 12'h5E9, {7'h7F, 7'h40, 7'h01}, 2, 4'h5, 7'h7F};
    vecs[7] = '{3'b010, 12'hCBA, {7'h33, 7'h22, 7'h11}, 1, 4'hB, 7'h22};
    vecs[8] = '{3'b110, 12'h5E9, {7'h7F, 7'h40, 7'h01}, 2, 4'h5, 7'h7F};

    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    AWREADY  = 1'b1;
    WREADY   = 1'b1;
    BVALID   = 1'b1;
    repeat (2) @(negedge ACLK);
    check("reset outputs", 32'({AWVALID, WVALID, BREADY, err, busy, done, AWADDR, WDATA}), 32'(0));
    reset = 1'b0;
    @(negedge ACLK);
    check("idle no req busy", 32'({busy, AWVALID}), 32'(0));

    // Single request latency with an always-ready slave
    req      = 3'b001;
    req_addr = 12'h003;
    req_data = {7'h00, 7'h00, 7'h55};
    @(negedge ACLK);
    check("lat e0 valids", 32'({AWVALID, WVALID, BREADY, busy}), 32'(4'b1101));
    check("lat e0 AWADDR", 32'(AWADDR), 32'(4'h3));
    check("lat e0 WDATA", 32'(WDATA), 32'(7'h55));
    @(negedge ACLK);
    check("lat e1 valids", 32'({AWVALID, WVALID, BREADY}), 32'(3'b001));
    @(negedge ACLK);
    check("lat e2 bready/done", 32'({BREADY, done}), 32'(0));
    @(negedge ACLK);
    check("lat e3 done", 32'(done), 32'(3'b001));
    check("lat e3 err/busy", 32'({err, busy}), 32'(0));
    req = 3'b000;
    @(negedge ACLK);
    check("lat e4 done pulse", 32'(done), 32'(0));

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Skewed handshakes on requester 2, inputs changed and req dropped after grant
    AWREADY  = 1'b1;
    WREADY   = 1'b0;
    req      = 3'b100;
    req_addr = {4'h6, 8'h00};
    req_data = {7'h11, 14'h0};
    @(negedge ACLK);
    check("skew e0 valids", 32'({AWVALID, WVALID}), 32'(2'b11));
    check("skew e0 AWADDR", 32'(AWADDR), 32'(4'h6));
    req_data = {7'h22, 14'h0};
    req_addr = {4'h9, 8'h00};
    req      = 3'b000;
    @(negedge ACLK);
    check("skew e1 valids", 32'({AWVALID, WVALID, BREADY}), 32'(3'b010));
    check("skew e1 WDATA", 32'(WDATA), 32'(7'h11));
    for (int k = 2; k <= 4; k++) begin
      @(negedge ACLK);
      check($sformatf("skew e%0d W/B", k), 32'({WVALID, BREADY}), 32'(2'b10));
      check($sformatf("skew e%0d WDATA", k), 32'(WDATA), 32'(7'h11));
      check($sformatf("skew e%0d AWADDR", k), 32'(AWADDR), 32'(4'h6));
    end
    WREADY = 1'b1;
    @(negedge ACLK);
    check("skew e5 W/B", 32'({WVALID, BREADY}), 32'(2'b01));
    @(negedge ACLK);
    check("skew e6 done", 32'(done), 32'(0));
    @(negedge ACLK);
    check("skew e7 done", 32'(done), 32'(3'b100));
    check("skew e7 err", 32'(err), 32'(0));

    // B-channel timeout
    BVALID = 1'b0;
    req    = 3'b010;
    n      = 0;
    fell   = 1'b0;
    for (int c = 0; c < 40 && !fell; c++) begin
      @(negedge ACLK);
      if (BREADY) n++;
      else if (n > 0) fell = 1'b1;
    end
    check("tmo bready cycles", 32'(n), 32'(TMO));
    check("tmo done before pulse", 32'(done), 32'(0));
    @(negedge ACLK);
    check("tmo done", 32'(done), 32'(3'b010));
    check("tmo err/busy", 32'({err, busy}), 32'(2'b10));
    req = 3'b000;
    @(negedge ACLK);
    check("tmo pulse end", 32'({done, err}), 32'(0));

    // Reset in RESP abandons the transaction
    req      = 3'b001;
    req_addr = {4'h0, 4'h7, 4'h4};
    hit      = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge ACLK);
      if (BREADY) hit = 1'b1;
    end
    check("rst reached RESP", 32'(hit), 32'(1));
    reset = 1'b1;
    #1;
    check("rst async outputs", 32'({AWVALID, WVALID, BREADY, err, busy, done, AWADDR, WDATA}), 32'(0));
    req    = 3'b010;
    BVALID = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge ACLK);
      check("rst held done", 32'(done), 32'(0));
    end
    reset = 1'b0;
    @(negedge ACLK);
    check("rst regrant valid", 32'(AWVALID), 32'(1));
    check("rst regrant AWADDR", 32'(AWADDR), 32'(4'h7));
    repeat (3) @(negedge ACLK);
    check("rst regrant done", 32'(done), 32'(3'b010));
    req = 3'b000;
    @(negedge ACLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
